// File: rtl/mdu_div.sv
// mdu_div: iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU.
// It has no subtractor of its own. During ITER it borrows the ALU's 34-bit adder
// and performs one restoring-division step per cycle. Results go to writeback
// through a valid/ready handshake.

package mdu_div_pkg;
    // Adder operands driven to the ALU. Bit 0 of each operand is a carry-in slot.
    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
    } mdu2alu_t;

    // Sum returned by the ALU. res[33] is the carry-out, res[32:1] is the difference.
    typedef struct packed {
        logic [33:0] res;
        logic        not_zero;
    } alu2mdu_t;
endpackage

module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             mdu_valid,
    output mdu2alu_t         mdu2alu,
    input  alu2mdu_t         alu2mdu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encoding of in_op: bit 0 set means unsigned, bit 1 set means remainder.
    localparam int OP_UNSIGNED_BIT = 0;
    localparam int OP_REM_BIT      = 1;

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         op_r;
    logic [TAG_W-1:0]   tag_r;
    logic               neg_quo_r;
    logic               neg_rem_r;
    logic [31:0]        divisor_r;
    logic [31:0]        rem_r;
    logic [31:0]        quo_r;
    logic [4:0]         cnt_r;
    logic [31:0]        result_r;
    logic [TAG_W-1:0]   result_tag_r;

    logic               accept;
    logic               last_iter;
    logic               op_signed;
    logic               b_is_zero;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [32:0]        shifted;
    logic               q_bit;
    logic [31:0]        rem_nxt;
    logic [31:0]        quo_nxt;
    logic [31:0]        fixed_result;
    logic [31:0]        zero_div_result;

    // Two's-complement negation when requested. Used both to form magnitudes
    // and to apply the sign fixup to the final quotient and remainder.
    function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic neg);
        logic signed [31:0] sv;
        sv = v;
        if (neg) begin
            return 32'(-sv);
        end
        return v;
    endfunction

    // Final sign fixup and quotient/remainder selection.
    function automatic logic [31:0] select_result(
        input logic [31:0] quo,
        input logic [31:0] rem,
        input logic        neg_quo,
        input logic        neg_rem,
        input logic        want_rem
    );
        logic [31:0] q_fix;
        logic [31:0] r_fix;
        q_fix = cond_negate(quo, neg_quo);
        r_fix = cond_negate(rem, neg_rem);
        return want_rem ? r_fix : q_fix;
    endfunction

    // The low carry-in bit and the not_zero flag of the ALU are not needed here.
    logic unused_alu;
    assign unused_alu = ^{alu2mdu.res[0], alu2mdu.not_zero};

    // Operand decode for the accepting cycle.
    always_comb begin
        op_signed       = ~in_op[OP_UNSIGNED_BIT];
        b_is_zero       = (in_b == 32'd0);
        abs_a           = cond_negate(in_a, op_signed & in_a[31]);
        abs_b           = cond_negate(in_b, op_signed & in_b[31]);
        zero_div_result = in_op[OP_REM_BIT] ? in_a : 32'hFFFF_FFFF;
    end

    // One restoring step: shift in the next dividend bit, then keep the ALU
    // difference if it did not borrow. A set shifted[32] means the partial
    // remainder already exceeds any 32-bit divisor, so the subtract is forced.
    always_comb begin
        shifted      = {rem_r, quo_r[31]};
        q_bit        = alu2mdu.res[33] | shifted[32];
        rem_nxt      = q_bit ? alu2mdu.res[32:1] : shifted[31:0];
        quo_nxt      = {quo_r[30:0], q_bit};
        fixed_result = select_result(quo_nxt, rem_nxt, neg_quo_r, neg_rem_r,
                                     op_r[OP_REM_BIT]);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the handshake and adder-borrow outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mdu_valid = 1'b0;
        mdu2alu   = '0;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid & ~flush;
                if (accept) begin
                    state_nxt = b_is_zero ? DONE : ITER;
                end
            end
            ITER: begin
                mdu_valid = 1'b1;
                // a - b is computed as a + ~b + 1. The +1 comes from the two
                // low-order 1 bits, which carry into bit 1.
                mdu2alu.a = {shifted[31:0], 1'b1};
                mdu2alu.b = {~divisor_r, 1'b1};
                last_iter = (cnt_r == 5'd31);
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // A flush that arrives together with out_ready still kills the
                // result. Either way the next state is IDLE.
                if (flush || out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and registered result fixup.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_r         <= 2'd0;
            tag_r        <= '0;
            neg_quo_r    <= 1'b0;
            neg_rem_r    <= 1'b0;
            divisor_r    <= 32'd0;
            rem_r        <= 32'd0;
            quo_r        <= 32'd0;
            cnt_r        <= 5'd0;
            result_r     <= 32'd0;
            result_tag_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r      <= in_op;
                        tag_r     <= in_tag;
                        neg_quo_r <= op_signed & (in_a[31] ^ in_b[31]);
                        neg_rem_r <= op_signed & in_a[31];
                        divisor_r <= abs_b;
                        cnt_r     <= 5'd0;
                        rem_r     <= 32'd0;
                        quo_r     <= abs_a;
                        if (b_is_zero) begin
                            // A zero divisor skips iteration. The result is
                            // all-ones for a quotient or the raw dividend for a
                            // remainder.
                            result_r     <= zero_div_result;
                            result_tag_r <= in_tag;
                        end
                    end
                end
                ITER: begin
                    if (!flush) begin
                        rem_r <= rem_nxt;
                        quo_r <= quo_nxt;
                        cnt_r <= cnt_r + 5'd1;
                        if (last_iter) begin
                            result_r     <= fixed_result;
                            result_tag_r <= tag_r;
                        end
                    end
                end
                default: begin
                    // DONE holds the result stable while writeback stalls.
                end
            endcase
        end
    end

    assign out_result = result_r;
    assign out_tag    = result_tag_r;

endmodule

// File: tb/tb_mdu_div.sv
// Directed testbench for mdu_div. A behavioural 34-bit adder stands in for the ALU.
module tb_mdu_div;
    import mdu_div_pkg::*;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        mdu_valid;
    mdu2alu_t    m2a;
    alu2mdu_t    a2m;

    int total = 0;
    int bad   = 0;

    mdu_div #(.TAG_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .mdu_valid  (mdu_valid),
        .mdu2alu    (m2a),
        .alu2mdu    (a2m)
    );

    // The ALU adder: a plain 34-bit sum of the two 33-bit operands.
    always_comb begin
        a2m.res      = {1'b0, m2a.a} + {1'b0, m2a.b};
        a2m.not_zero = |a2m.res;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one operation, checks latency and adder usage, holds backpressure
    // for 'hold' cycles, then completes the handshake.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int hold);
        int waits;
        int edges;
        int mdu_cnt;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clock); #1;
            waits++;
        end
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clock); #1;
        in_valid = 1'b0;
        edges    = 1;
        mdu_cnt  = 0;
        while (!out_valid && edges < 60) begin
            if (mdu_valid) mdu_cnt++;
            @(posedge clock); #1;
            edges++;
        end
        // Count edges with the accepting edge as edge 1.
        check({name, "_latency"}, 32'(edges), (b == 32'd0) ? 32'd1 : 32'd33);
        check({name, "_mdu_cycles"}, 32'(mdu_cnt), (b == 32'd0) ? 32'd0 : 32'd32);
        check({name, "_result"}, out_result, exp);
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
        check({name, "_done_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_done_mdu_valid"}, 32'(mdu_valid), 32'd0);
        check({name, "_done_m2a"}, 32'(|m2a), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_result"}, out_result, exp);
            check({name, "_hold_tag"}, 32'(out_tag), 32'(tag));
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({name, "_after_valid"}, 32'(out_valid), 32'd0);
        check({name, "_after_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = 5'd0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mdu_valid", 32'(mdu_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_m2a", 32'(|m2a), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;

        // Unsigned and signed basics.
        run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 5'd1, 32'd14, 0);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 5'd2, 32'd2, 0);
        run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 0);
        run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 0);
        run_op("rem_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'd1, 0);

        // Divide by zero.
        run_op("div_5_0", 2'd0, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 0);
        run_op("rem_5_0", 2'd2, 32'd5, 32'd0, 5'd7, 32'd5, 0);
        run_op("rem_min_0", 2'd2, 32'h8000_0000, 32'd0, 5'd8, 32'h8000_0000, 0);

        // Extremes and the signed overflow case.
        run_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'hFFFF_FFFF, 0);
        run_op("remu_max_1", 2'd3, 32'hFFFF_FFFF, 32'd1, 5'd10, 32'd0, 0);
        run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
        run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0);
        run_op("divu_min_max", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 0);
        run_op("remu_min_max", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0);
        run_op("divu_big_div", 2'd1, 32'hFFFF_FFFF, 32'h8000_0001, 5'd15, 32'd1, 0);
        run_op("remu_big_div", 2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 5'd16, 32'h7FFF_FFFE, 0);

        // Backpressure, followed immediately by a back-to-back op.
        run_op("bp_divu", 2'd1, 32'd1000, 32'd9, 5'd17, 32'd111, 5);
        run_op("bp_next", 2'd3, 32'd1000, 32'd9, 5'd18, 32'd1, 0);

        // A flush together with in_valid blocks acceptance.
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_a     = 32'd50;
        in_b     = 32'd5;
        in_tag   = 5'd19;
        flush    = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_accept_in_ready", 32'(in_ready), 32'd1);
        check("flush_accept_mdu_valid", 32'(mdu_valid), 32'd0);

        // Flush at iteration 10.
        in_valid = 1'b1;
        in_tag   = 5'd20;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
        end
        check("flush_mid_mdu_before", 32'(mdu_valid), 32'd1);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_mid_mdu_valid", 32'(mdu_valid), 32'd0);
        check("flush_mid_out_valid", 32'(out_valid), 32'd0);
        check("flush_mid_in_ready", 32'(in_ready), 32'd1);
        check("flush_mid_m2a", 32'(|m2a), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clock); #1;
                if (out_valid || mdu_valid) seen++;
            end
            check("flush_no_result", 32'(seen), 32'd0);
        end

        // Asynchronous reset in the middle of ITER.
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_a     = 32'd77;
        in_b     = 32'd3;
        in_tag   = 5'd21;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
        end
        check("arst_pre_mdu_valid", 32'(mdu_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_mdu_valid", 32'(mdu_valid), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_tag", 32'(out_tag), 32'd0);
        check("arst_m2a", 32'(|m2a), 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clock); #1;
        run_op("post_rst_divu", 2'd1, 32'd77, 32'd3, 5'd22, 32'd25, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
